// File: rtl/fp_soc_onchip_mem_arbiter.sv
// fp_soc_onchip_mem_arbiter
// Two-master round-robin arbiter in front of a 4x32 single-port on-chip RAM
// (registered address, unregistered q). Master ports follow Avalon-MM slave
// behaviour; read data returns to the owning master with a registered
// readdatavalid pulse two cycles after the accept.
//
// Optional feature macro: ONCHIP_ARB_PERF_CNT_EN
//   defined     -> per-master saturating accepted-request counters
//   not defined -> mN_grant_cnt tied to zero, no counter registers
//
// Handshake: a master request (read|write) is accepted in the cycle where
// its request is high and its waitrequest is low; the master holds all
// request fields stable until then. waitrequest is low for a master that is
// not requesting. readdatavalid is a single-cycle registered pulse.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = RD_DATA.

module fp_soc_onchip_mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic [CNT_W-1:0]  m0_grant_cnt,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [CNT_W-1:0]  m1_grant_cnt,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              dbg_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              last_grant_d;
    logic              owner_q;
    logic              owner_d;
    logic [ADDR_W-1:0] addr_q;

    logic              req0;
    logic              req1;
    logic              win;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [BE_W-1:0]   win_be;
    logic [DATA_W-1:0] win_data;

    logic              grant0;
    logic              grant1;
    logic              rd_done;

    // A request is a write whenever write is set, even if read is also set.
    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Round-robin winner selection and mux of the winning request fields.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_grant_q;
        end else begin
            win = req1;
        end
        win_write = win ? m1_write      : m0_write;
        win_addr  = win ? m1_address    : m0_address;
        win_be    = win ? m1_byteenable : m0_byteenable;
        win_data  = win ? m1_writedata  : m0_writedata;
    end

    // FSM next state, RAM drive and waitrequest generation.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        grant0         = 1'b0;
        grant1         = 1'b0;
        rd_done        = 1'b0;
        m0_waitrequest = 1'b0;
        m1_waitrequest = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = addr_q;
        mem_byteenable = '0;
        mem_writedata  = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant0         = ~win;
                    grant1         = win;
                    m0_waitrequest = req0 & win;
                    m1_waitrequest = req1 & ~win;
                    mem_chipselect = 1'b1;
                    mem_write      = win_write;
                    mem_address    = win_addr;
                    mem_byteenable = win_write ? win_be : '1;
                    mem_writedata  = win_write ? win_data : '0;
                    last_grant_d   = win;
                    if (!win_write) begin
                        state_d = RD_DATA;
                        owner_d = win;
                    end
                end
            end
            RD_DATA: begin
                // RAM q is valid this cycle; nobody is accepted.
                m0_waitrequest = req0;
                m1_waitrequest = req1;
                rd_done        = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, fairness pointer, read owner and held RAM address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            if (grant0 || grant1) begin
                addr_q <= win_addr;
            end
        end
    end

    // Registered read-data return to the owning master.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= rd_done & ~owner_q;
            m1_readdatavalid <= rd_done & owner_q;
            if (rd_done && !owner_q) begin
                m0_readdata <= mem_readdata;
            end
            if (rd_done && owner_q) begin
                m1_readdata <= mem_readdata;
            end
        end
    end

`ifdef ONCHIP_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating accepted-request counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant0 && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (grant1 && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign m0_grant_cnt = cnt0_q;
    assign m1_grant_cnt = cnt1_q;
`else
    assign m0_grant_cnt = '0;
    assign m1_grant_cnt = '0;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_soc_onchip_mem_arbiter.sv
// Testbench for fp_soc_onchip_mem_arbiter: directed vector table followed by
// randomized traffic checked against a transaction-level reference model.
// A second instance with CNT_W=2 shares all inputs to exercise counter
// saturation.

module tb_fp_soc_onchip_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_grant_cnt, m1_grant_cnt;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;
    logic        dbg_state;

    // Saturation instance outputs
    logic        s_m0_waitrequest, s_m1_waitrequest;
    logic [31:0] s_m0_readdata, s_m1_readdata;
    logic        s_m0_readdatavalid, s_m1_readdatavalid;
    logic [1:0]  s_m0_grant_cnt, s_m1_grant_cnt;
    logic [1:0]  s_mem_address;
    logic [3:0]  s_mem_byteenable;
    logic        s_mem_chipselect, s_mem_write;
    logic [31:0] s_mem_writedata;
    logic        s_dbg_state;

    fp_soc_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_grant_cnt(m0_grant_cnt),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_grant_cnt(m1_grant_cnt),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .dbg_state(dbg_state)
    );

    fp_soc_onchip_mem_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(s_m0_waitrequest), .m0_readdata(s_m0_readdata),
        .m0_readdatavalid(s_m0_readdatavalid), .m0_grant_cnt(s_m0_grant_cnt),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(s_m1_waitrequest), .m1_readdata(s_m1_readdata),
        .m1_readdatavalid(s_m1_readdatavalid), .m1_grant_cnt(s_m1_grant_cnt),
        .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
        .mem_chipselect(s_mem_chipselect), .mem_write(s_mem_write),
        .mem_writedata(s_mem_writedata), .mem_readdata(mem_readdata),
        .dbg_state(s_dbg_state)
    );

    // ---------------- RAM environment (registered address, comb q) ----------------
    logic [31:0] ram [4];
    logic [1:0]  ram_addr_q = 2'd0;
    always @(posedge clk) begin
        ram_addr_q <= mem_address;
        if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    // ---------------- vectors ----------------
    typedef struct {
        bit          rst;
        logic        r0, w0;
        logic [1:0]  a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [1:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        e_wait0, e_wait1, e_cs, e_we;
        logic [1:0]  e_addr;
        logic        e_rdv0, e_rdv1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    typedef struct packed {
        logic        r, w;
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } req_t;

    int errors = 0;
    int checks = 0;
    int cnt0 = 0;
    int cnt1 = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t row(input int rst, input int r0, input int w0, input int a0,
                                 input int be0, input logic [31:0] d0,
                                 input int r1, input int w1, input int a1,
                                 input int be1, input logic [31:0] d1,
                                 input int ew0, input int ew1, input int ecs, input int ewe,
                                 input int ea, input int rv0, input int rv1,
                                 input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.rst = rst[0];   v.r0 = r0[0];   v.w0 = w0[0];   v.a0 = a0[1:0];
        v.be0 = be0[3:0]; v.d0 = d0;      v.r1 = r1[0];   v.w1 = w1[0];
        v.a1 = a1[1:0];   v.be1 = be1[3:0]; v.d1 = d1;
        v.e_wait0 = ew0[0]; v.e_wait1 = ew1[0]; v.e_cs = ecs[0]; v.e_we = ewe[0];
        v.e_addr = ea[1:0]; v.e_rdv0 = rv0[0]; v.e_rdv1 = rv1[0];
        v.e_rd0 = rd0;    v.e_rd1 = rd1;
        return v;
    endfunction

    // Drive one cycle, check combinational outputs mid-cycle and registered
    // outputs just after the clock edge. Called at posedge+1.
    task automatic step(input vec_t v);
        logic acc0, acc1, rd_acc;
        int   exp_c0, exp_c1;
        reset = v.rst;
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
        #2;
        acc0   = (v.r0 | v.w0) & ~v.e_wait0;
        acc1   = (v.r1 | v.w1) & ~v.e_wait1;
        rd_acc = (acc0 & ~v.w0) | (acc1 & ~v.w1);
        chk("m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, v.e_wait0});
        chk("m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, v.e_wait1});
        chk("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, v.e_cs});
        chk("mem_write", {31'b0, mem_write}, {31'b0, v.e_we});
        if (v.e_cs) begin
            chk("mem_address", {30'b0, mem_address}, {30'b0, v.e_addr});
            chk("mem_byteenable", {28'b0, mem_byteenable},
                {28'b0, v.e_we ? (acc1 ? v.be1 : v.be0) : 4'hF});
        end
        if (v.e_we) chk("mem_writedata", mem_writedata, acc1 ? v.d1 : v.d0);
        @(posedge clk);
        #1;
        if (v.rst) begin
            cnt0 = 0;
            cnt1 = 0;
        end else begin
            cnt0 += int'(acc0);
            cnt1 += int'(acc1);
        end
        chk("m0_readdatavalid", {31'b0, m0_readdatavalid}, {31'b0, v.e_rdv0});
        chk("m1_readdatavalid", {31'b0, m1_readdatavalid}, {31'b0, v.e_rdv1});
        chk("m0_readdata", m0_readdata, v.e_rd0);
        chk("m1_readdata", m1_readdata, v.e_rd1);
        chk("state", {31'b0, dbg_state}, {31'b0, (~v.rst) & rd_acc});
`ifdef ONCHIP_ARB_PERF_CNT_EN
        exp_c0 = cnt0;
        exp_c1 = cnt1;
`else
        exp_c0 = 0;
        exp_c1 = 0;
`endif
        chk("m0_grant_cnt", {16'b0, m0_grant_cnt}, exp_c0);
        chk("m1_grant_cnt", {16'b0, m1_grant_cnt}, exp_c1);
        chk("m0_grant_cnt_sat", {30'b0, s_m0_grant_cnt}, (exp_c0 > 3) ? 3 : exp_c0);
        chk("m1_grant_cnt_sat", {30'b0, s_m1_grant_cnt}, (exp_c1 > 3) ? 3 : exp_c1);
    endtask

    function automatic req_t rand_req();
        req_t q;
        q.w  = 1'($urandom_range(0, 1));
        q.r  = q.w ? 1'($urandom_range(0, 1)) : 1'b1;
        q.a  = 2'($urandom_range(0, 3));
        q.be = 4'($urandom_range(0, 15));
        q.d  = $urandom;
        return q;
    endfunction

    // ---------------- stimulus ----------------
    localparam logic [31:0] ZZ = 32'h0;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] X1 = 32'h11223344;
    localparam logic [31:0] X2 = 32'hAABBCCDD;
    localparam logic [31:0] MX = 32'h11BB33DD;
    localparam logic [31:0] A0 = 32'hA0A0A0A0;
    localparam logic [31:0] A2 = 32'hA2A2A2A2;
    localparam logic [31:0] B1 = 32'hB1B1B1B1;
    localparam logic [31:0] B3 = 32'hB3B3B3B3;
    localparam logic [31:0] C0 = 32'hC0C0C0C0;
    localparam logic [31:0] D1 = 32'hD1D1D1D1;
    localparam logic [31:0] E0 = 32'hE0E0E0E0;
    localparam logic [31:0] E1 = 32'hE1E1E1E1;

    vec_t tbl [26];

    // Reference model state (transaction level)
    logic [31:0] exp_mem [4];
    logic        m_busy, m_owner, m_last;
    logic [31:0] m_pend;
    logic [31:0] m_rd [2];

    initial begin
        req_t p0, p1;
        vec_t v;
        logic rst_now, rq0, rq1, w;
        logic [3:0] wbe;
        logic [1:0] wa;
        logic [31:0] wd;

        // rst, m0{r,w,a,be,d}, m1{r,w,a,be,d}, exp{wait0,wait1,cs,we,addr}, rdv0, rdv1, rd0, rd1
        tbl[0]  = row(1, 0,0,0,0,ZZ, 0,0,0,0,ZZ, 0,0,0,0,0, 0,0, ZZ,ZZ);
        tbl[1]  = row(0, 0,0,0,0,ZZ, 0,0,0,0,ZZ, 0,0,0,0,0, 0,0, ZZ,ZZ);
        // m0 write then read back at accept+2
        tbl[2]  = row(0, 0,1,2,15,DB, 0,0,0,0,ZZ, 0,0,1,1,2, 0,0, ZZ,ZZ);
        tbl[3]  = row(0, 1,0,2,0,ZZ,  0,0,0,0,ZZ, 0,0,1,0,2, 0,0, ZZ,ZZ);
        tbl[4]  = row(0, 0,0,0,0,ZZ,  0,0,0,0,ZZ, 0,0,0,0,0, 1,0, DB,ZZ);
        tbl[5]  = row(0, 0,0,0,0,ZZ,  0,0,0,0,ZZ, 0,0,0,0,0, 0,0, DB,ZZ);
        // m1 byte-lane merge
        tbl[6]  = row(0, 0,0,0,0,ZZ, 0,1,1,15,X1, 0,0,1,1,1, 0,0, DB,ZZ);
        tbl[7]  = row(0, 0,0,0,0,ZZ, 0,1,1,5,X2,  0,0,1,1,1, 0,0, DB,ZZ);
        tbl[8]  = row(0, 0,0,0,0,ZZ, 1,0,1,0,ZZ,  0,0,1,0,1, 0,0, DB,ZZ);
        tbl[9]  = row(0, 0,0,0,0,ZZ, 0,0,0,0,ZZ,  0,0,0,0,0, 0,1, DB,MX);
        // reset, then contended writes alternate m0,m1,m0,m1
        tbl[10] = row(1, 0,0,0,0,ZZ,  0,0,0,0,ZZ,  0,0,0,0,0, 0,0, ZZ,ZZ);
        tbl[11] = row(0, 0,1,0,15,A0, 0,1,3,15,B1, 0,1,1,1,0, 0,0, ZZ,ZZ);
        tbl[12] = row(0, 0,1,0,15,A2, 0,1,3,15,B1, 1,0,1,1,3, 0,0, ZZ,ZZ);
        tbl[13] = row(0, 0,1,0,15,A2, 0,1,3,15,B3, 0,1,1,1,0, 0,0, ZZ,ZZ);
        tbl[14] = row(0, 0,1,2,15,C0, 0,1,3,15,B3, 1,0,1,1,3, 0,0, ZZ,ZZ);
        tbl[15] = row(0, 0,1,2,15,C0, 0,0,0,0,ZZ,  0,0,1,1,2, 0,0, ZZ,ZZ);
        // m0 read, m1 write stalled for one cycle in RD_DATA
        tbl[16] = row(0, 1,0,0,0,ZZ, 0,0,0,0,ZZ,  0,0,1,0,0, 0,0, ZZ,ZZ);
        tbl[17] = row(0, 0,0,0,0,ZZ, 0,1,3,15,D1, 0,1,0,0,0, 1,0, A2,ZZ);
        tbl[18] = row(0, 0,0,0,0,ZZ, 0,1,3,15,D1, 0,0,1,1,3, 0,0, A2,ZZ);
        // reset during RD_DATA drops the read; next tie goes to m0
        tbl[19] = row(0, 1,0,3,0,ZZ,  0,0,0,0,ZZ,  0,0,1,0,3, 0,0, A2,ZZ);
        tbl[20] = row(1, 0,0,0,0,ZZ,  0,0,0,0,ZZ,  0,0,0,0,0, 0,0, ZZ,ZZ);
        tbl[21] = row(0, 0,0,0,0,ZZ,  0,0,0,0,ZZ,  0,0,0,0,0, 0,0, ZZ,ZZ);
        tbl[22] = row(0, 0,1,1,15,E0, 0,1,1,15,E1, 0,1,1,1,1, 0,0, ZZ,ZZ);
        tbl[23] = row(0, 0,0,0,0,ZZ,  0,1,1,15,E1, 0,0,1,1,1, 0,0, ZZ,ZZ);
        tbl[24] = row(0, 0,0,0,0,ZZ,  1,0,1,0,ZZ,  0,0,1,0,1, 0,0, ZZ,ZZ);
        tbl[25] = row(0, 0,0,0,0,ZZ,  0,0,0,0,ZZ,  0,0,0,0,0, 0,1, ZZ,E1);

        // Initial reset
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_address", {30'b0, mem_address}, 32'd0);

        for (int i = 0; i < 26; i++) step(tbl[i]);

        // ---------------- randomized phase ----------------
        exp_mem[0] = A2; exp_mem[1] = E1; exp_mem[2] = C0; exp_mem[3] = D1;
        step(row(1, 0,0,0,0,ZZ, 0,0,0,0,ZZ, 0,0,0,0,0, 0,0, ZZ,ZZ));
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_pend = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        p0 = '0; p1 = '0;

        for (int c = 0; c < 600; c++) begin
            rst_now = ($urandom_range(0, 59) == 0);
            if (rst_now) begin
                p0 = '0;
                p1 = '0;
            end else begin
                if (!(p0.r | p0.w) && $urandom_range(0, 9) < 6) p0 = rand_req();
                if (!(p1.r | p1.w) && $urandom_range(0, 9) < 6) p1 = rand_req();
            end
            rq0 = p0.r | p0.w;
            rq1 = p1.r | p1.w;
            v = row(int'(rst_now), int'(p0.r), int'(p0.w), int'(p0.a), int'(p0.be), p0.d,
                    int'(p1.r), int'(p1.w), int'(p1.a), int'(p1.be), p1.d,
                    0,0,0,0,0, 0,0, ZZ,ZZ);
            w = 1'b0;
            if (m_busy) begin
                v.e_wait0 = rq0;
                v.e_wait1 = rq1;
            end else if (rq0 || rq1) begin
                w = (rq0 && rq1) ? ~m_last : rq1;
                v.e_wait0 = rq0 & w;
                v.e_wait1 = rq1 & ~w;
                v.e_cs    = 1'b1;
                v.e_we    = w ? p1.w : p0.w;
                v.e_addr  = w ? p1.a : p0.a;
            end
            if (rst_now) begin
                v.e_rd0 = '0;
                v.e_rd1 = '0;
            end else begin
                v.e_rdv0 = m_busy & ~m_owner;
                v.e_rdv1 = m_busy & m_owner;
                v.e_rd0  = (m_busy && !m_owner) ? m_pend : m_rd[0];
                v.e_rd1  = (m_busy && m_owner)  ? m_pend : m_rd[1];
            end
            step(v);
            // Model update after the edge
            if (rst_now) begin
                m_busy = 1'b0; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
            end else if (m_busy) begin
                m_rd[m_owner] = m_pend;
                m_busy = 1'b0;
            end else if (v.e_cs) begin
                m_last = w;
                wa  = w ? p1.a : p0.a;
                wbe = w ? p1.be : p0.be;
                wd  = w ? p1.d : p0.d;
                if (v.e_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbe[b]) exp_mem[wa][8*b +: 8] = wd[8*b +: 8];
                    end
                end else begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_pend  = exp_mem[wa];
                end
                if (w) p1 = '0;
                else   p0 = '0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
